// File: rtl/mulu_int.sv
// Iterative unsigned multiplier: one multiplier bit per clock, shift-add over a
// single WIDTH+1-bit adder, fixed latency of WIDTH cycles from the start edge.
`timescale 1ns/1ps
module mulu_int #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  output logic [2*WIDTH-1:0]   val,
  output logic                 ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  logic                 r_state;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_a;
  logic [2*WIDTH-1:0]   r_prod;
  logic [2*WIDTH-1:0]   r_val;
  logic                 r_ovf;
  logic                 r_valid;
  logic                 r_done;

  logic [WIDTH:0]       w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_prod_next;
  logic                 w_last;

  // Upper half accumulates, lower half starts as the multiplier and shifts out
  // its LSB each step while the sum's carry enters from the top.
  assign w_addend    = r_prod[0] ? {1'b0, r_a} : '0;
  assign w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + w_addend;
  assign w_prod_next = {w_sum, r_prod[WIDTH-1:1]};
  assign w_last      = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_prod  <= '0;
      r_val   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        // A new request always wins, even over a final iteration in flight.
        r_state <= S_RUN;
        r_cnt   <= '0;
        r_a     <= a;
        r_prod  <= {{WIDTH{1'b0}}, b};
        r_valid <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_prod <= w_prod_next;
        r_cnt  <= r_cnt + CW'(1);
        if (w_last) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_val   <= w_prod_next;
          r_ovf   <= |w_prod_next[2*WIDTH-1:WIDTH];
          r_valid <= 1'b1;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign busy  = (r_state == S_RUN);
  assign done  = r_done;
  assign valid = r_valid;
  assign val   = r_val;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_mulu_int.sv
// Bench for mulu_int (WIDTH=8): directed table, multi-cycle corner sequences
// and random back-to-back requests, checked through an expected-result queue.
`timescale 1ns/1ps
module tb_mulu_int;

  logic        clk, rst, start;
  logic [7:0]  a, b;
  logic        busy, done, valid, ovf;
  logic [15:0] val;

  mulu_int #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .valid(valid), .val(val), .ovf(ovf)
  );

  typedef struct { logic [7:0] a; logic [7:0] b; logic [15:0] v; logic o; } vec_t;
  typedef struct { logic [15:0] v; logic o; int sedge; } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ndone = 0;
  int   exp_dones = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
    end
  endfunction

  // Output monitor: every done pops one expected result and checks it.
  always @(negedge clk) begin
    if (done) begin
      ndone++;
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("val", 32'(val), 32'(e.v));
        chk("ovf", 32'(ovf), 32'(e.o));
        chk("latency", 32'(cyc - e.sedge), 32'd8);
        chk("valid_at_done", 32'(valid), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] ev, input logic eo);
    exp_t e;
    a = x;
    b = y;
    start = 1'b1;
    sb.delete();
    e.v = ev;
    e.o = eo;
    e.sedge = cyc + 1;
    sb.push_back(e);
    step();
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n0;
    int k;
    n0 = ndone;
    k = 0;
    while (ndone == n0 && k < budget) begin
      step();
      k++;
    end
    if (ndone == n0) begin
      total++;
      bad++;
      $display("FAIL timeout: no done within %0d cycles", budget);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[7];
    int   bc;
    logic [7:0]  x, y;
    logic [15:0] p;

    tv[0] = '{8'hFF, 8'hFF, 16'hFE01, 1'b1};
    tv[1] = '{8'd12,  8'd10,  16'h0078, 1'b0};
    tv[2] = '{8'h00, 8'hA5, 16'h0000, 1'b0};
    tv[3] = '{8'h10, 8'h10, 16'h0100, 1'b1};
    tv[4] = '{8'h01, 8'hFF, 16'h00FF, 1'b0};
    tv[5] = '{8'hFF, 8'h01, 16'h00FF, 1'b0};
    tv[6] = '{8'h80, 8'h02, 16'h0100, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    a = 8'h5A;
    b = 8'hC3;
    repeat (2) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_val", 32'(val), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      start_op(tv[i].a, tv[i].b, tv[i].v, tv[i].o);
      exp_dones++;
      chk("valid_after_start", 32'(valid), 32'd0);
      wait_done(20);
    end

    // 0xFF*0xFF: busy must be visible for exactly 8 cycles.
    bc = 0;
    start_op(8'hFF, 8'hFF, 16'hFE01, 1'b1);
    exp_dones++;
    for (int k = 0; k < 12; k++) begin
      if (busy) bc++;
      if (done) break;
      step();
    end
    chk("busy_cycles", 32'(bc), 32'd8);

    // Restart three cycles in: only the second request completes.
    start_op(8'd3, 8'd5, 16'd15, 1'b0);
    step();
    step();
    start_op(8'd7, 8'd9, 16'h003F, 1'b0);
    exp_dones++;
    wait_done(20);

    // Start coinciding with the final iteration of the previous request.
    start_op(8'h11, 8'h11, 16'h0121, 1'b1);
    repeat (7) step();
    start_op(8'd4, 8'd4, 16'h0010, 1'b0);
    exp_dones++;
    chk("collide_done", 32'(done), 32'd0);
    chk("collide_valid", 32'(valid), 32'd0);
    chk("collide_val_kept", 32'(val), 32'h003F);
    wait_done(20);

    // Reset four cycles into a calculation, then an immediate new request.
    start_op(8'hFF, 8'hFF, 16'hFE01, 1'b1);
    repeat (3) step();
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_val", 32'(val), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    step();
    rst = 1'b0;
    start_op(8'd2, 8'd3, 16'h0006, 1'b0);
    exp_dones++;
    wait_done(20);

    // Random requests, each issued on the cycle the previous done is seen.
    for (int i = 0; i < 3000; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      p = {8'h00, x} * {8'h00, y};
      start_op(x, y, p, p[15:8] != 8'h00);
      exp_dones++;
      wait_done(20);
    end

    repeat (12) step();
    chk("done_count", 32'(ndone), 32'(exp_dones));
    chk("queue_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
